// File: rtl/crc32_frame_ctrl_pkg.sv
// Shared CRC32 constants, FSM state type and length helper for the frame sequencer.
package crc32_frame_ctrl_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04c11db7;
  localparam logic [31:0] CRC32_INIT    = 32'hffffffff;
  localparam logic [31:0] CRC32_XOR_OUT = 32'hffffffff;
  localparam logic [31:0] CRC32_RESIDUE = 32'hdebb20e3;
  localparam logic [15:0] LEN_MAX       = 16'hffff;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_RESULT
  } frame_state_t;

  function automatic logic [15:0] len_inc(input logic [15:0] len);
    return (len == LEN_MAX) ? LEN_MAX : len + 16'd1;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Combinational LFSR/CRC step: advances state_in by DATA_WIDTH input bits in one cycle.
module lfsr #(
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = LFSR_WIDTH'(32'h04c11db7),
  parameter string                 LFSR_CONFIG = "GALOIS",
  parameter bit                    REVERSE     = 1'b1,
  parameter int                    DATA_WIDTH  = 8,
  parameter string                 STYLE       = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam int W      = LFSR_WIDTH;
  localparam int D      = DATA_WIDTH;
  localparam int T      = W + D;
  localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");

  // Reflected operation is the MSB-first shift applied to bit-reversed state and data.
  function automatic logic [T-1:0] step(input logic [W-1:0] s_in, input logic [D-1:0] d_in);
    logic [W-1:0] s;
    logic [D-1:0] d;
    logic [D-1:0] d_out;
    logic         fb;
    s     = s_in;
    d     = d_in;
    d_out = '0;
    if (REVERSE) begin
      s = {<<{s}};
      d = {<<{d}};
    end
    for (int i = D - 1; i >= 0; i--) begin
      d_out[i] = s[W-1];
      if (GALOIS) begin
        fb = s[W-1] ^ d[i];
        s  = {s[W-2:0], 1'b0} ^ (fb ? LFSR_POLY : '0);
      end else begin
        fb = (^(s & LFSR_POLY)) ^ d[i];
        s  = {s[W-2:0], fb};
      end
    end
    if (REVERSE) begin
      s     = {<<{s}};
      d_out = {<<{d_out}};
    end
    return {d_out, s};
  endfunction

  function automatic logic [T-1:0] column_mask(input int out_bit);
    logic [T-1:0] m;
    logic [T-1:0] u;
    logic [T-1:0] r;
    m = '0;
    for (int k = 0; k < T; k++) begin
      u    = '0;
      u[k] = 1'b1;
      r    = step(u[T-1:D], u[D-1:0]);
      m[k] = r[out_bit];
    end
    return m;
  endfunction

  logic [T-1:0] w_out;

  if (STYLE == "REDUCTION") begin : g_reduction
    for (genvar gi = 0; gi < T; gi++) begin : g_bit
      localparam logic [T-1:0] MASK = column_mask(gi);
      assign w_out[gi] = ^({state_in, data_in} & MASK);
    end
  end else begin : g_loop
    assign w_out = step(state_in, data_in);
  end

  assign {data_out, state_out} = w_out;

endmodule

// File: rtl/crc32_frame_ctrl.sv
// Frame-level CRC32 sequencer: one byte per cycle through lfsr, result presented on a valid/ready handshake.
module crc32_frame_ctrl
  import crc32_frame_ctrl_pkg::*;
#(
  parameter logic [31:0] LFSR_POLY = CRC32_POLY,
  parameter logic [31:0] CRC_INIT  = CRC32_INIT,
  parameter logic [31:0] XOR_OUT   = CRC32_XOR_OUT,
  parameter logic [31:0] RESIDUE   = CRC32_RESIDUE,
  parameter string       STYLE     = "AUTO"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic [31:0] m_crc,
  output logic        m_crc_ok,
  output logic [15:0] m_len,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy
);

  frame_state_t r_state, w_state_next;

  logic [31:0] r_crc;
  logic [15:0] r_len;
  logic [31:0] r_m_crc;
  logic        r_m_ok;
  logic [15:0] r_m_len;

  logic [31:0] w_lfsr_state_in;
  logic [31:0] w_lfsr_state_out;
  logic [7:0]  w_unused_data_out;
  logic [15:0] w_len_next;
  logic        w_beat;
  logic        w_take;

  lfsr #(
    .LFSR_WIDTH  (32),
    .LFSR_POLY   (LFSR_POLY),
    .LFSR_CONFIG ("GALOIS"),
    .REVERSE     (1'b1),
    .DATA_WIDTH  (8),
    .STYLE       (STYLE)
  ) u_lfsr (
    .data_in   (s_data),
    .state_in  (w_lfsr_state_in),
    .data_out  (w_unused_data_out),
    .state_out (w_lfsr_state_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    s_ready         = 1'b0;
    m_valid         = 1'b0;
    w_lfsr_state_in = r_crc;
    case (r_state)
      ST_IDLE: begin
        s_ready         = !rst;
        w_lfsr_state_in = CRC_INIT;
        if (s_valid && !rst) begin
          w_state_next = s_last ? ST_RESULT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        s_ready = !rst;
        if (s_valid && !rst && s_last) begin
          w_state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_beat     = s_valid && s_ready;
  assign w_take     = m_valid && m_ready;
  assign w_len_next = (r_state == ST_IDLE) ? 16'd1 : len_inc(r_len);

  // Result fields are captured with the last beat so they stay frozen through the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc   <= CRC_INIT;
      r_len   <= '0;
      r_m_crc <= '0;
      r_m_ok  <= 1'b0;
      r_m_len <= '0;
    end else if (w_beat) begin
      r_crc <= w_lfsr_state_out;
      r_len <= w_len_next;
      if (s_last) begin
        r_m_crc <= w_lfsr_state_out ^ XOR_OUT;
        r_m_ok  <= (w_lfsr_state_out == RESIDUE);
        r_m_len <= w_len_next;
      end
    end else if (w_take) begin
      r_crc <= CRC_INIT;
      r_len <= '0;
    end
  end

  assign m_crc    = r_m_crc;
  assign m_crc_ok = r_m_ok;
  assign m_len    = r_m_len;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Self-checking bench for crc32_frame_ctrl against a table-driven CRC32 reference.
module tb_crc32_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [31:0] m_crc;
  logic        m_crc_ok;
  logic [15:0] m_len;
  logic        m_valid;
  logic        m_ready;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  frm[$];
  logic [31:0] tbl[256];

  crc32_frame_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_last   (s_last),
    .m_crc    (m_crc),
    .m_crc_ok (m_crc_ok),
    .m_len    (m_len),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register state after the frame in frm, byte-at-a-time table method.
  function automatic logic [31:0] ref_state();
    logic [31:0] st;
    st = 32'hffffffff;
    foreach (frm[k]) st = tbl[st[7:0] ^ frm[k]] ^ (st >> 8);
    return st;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_check_string();
    frm.delete();
    for (int k = 0; k < 9; k++) frm.push_back(8'(8'h31 + k));
  endtask

  task automatic send_frame(input string tag, input int gap_pct);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < frm.size()) begin
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = s_valid ? frm[i] : 8'($urandom);
      s_last  = s_valid && (i == frm.size() - 1);
      if (s_valid && s_ready) i++;
      tick();
      guard++;
      if (guard > 4 * frm.size() + 100) begin
        chk({tag, "_send_timeout"}, 32'(i), 32'(frm.size()));
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic take_result(input string tag, input int hold);
    logic [31:0] st;
    logic [31:0] ecrc;
    logic [31:0] elen;
    st   = ref_state();
    ecrc = st ^ 32'hffffffff;
    elen = (frm.size() > 65535) ? 32'hffff : 32'(frm.size());
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    chk({tag, "_crc"}, m_crc, ecrc);
    chk({tag, "_len"}, 32'(m_len), elen);
    chk({tag, "_ok"}, 32'(m_crc_ok), 32'(st == 32'hdebb20e3));
    $display("frame %s len=%0d crc=%h ok=%0d", tag, m_len, m_crc, m_crc_ok);
    for (int h = 0; h < hold; h++) begin
      m_ready = 1'b0;
      tick();
      chk({tag, "_hold_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_hold_crc"}, m_crc, ecrc);
      chk({tag, "_hold_sready"}, 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk({tag, "_taken_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_taken_sready"}, 32'(s_ready), 32'd1);
    chk({tag, "_taken_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
      tbl[n] = c;
    end

    rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    chk("reset_sready", 32'(s_ready), 32'd0);
    chk("reset_mvalid", 32'(m_valid), 32'd0);
    chk("reset_crc", m_crc, 32'd0);
    chk("reset_ok", 32'(m_crc_ok), 32'd0);
    chk("reset_len", 32'(m_len), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_sready", 32'(s_ready), 32'd1);

    // Check string with m_ready already high when the result appears.
    load_check_string();
    m_ready = 1'b1;
    send_frame("check", 0);
    chk("check_known_crc", m_crc, 32'hcbf43926);
    take_result("check", 0);

    frm.delete();
    frm.push_back(8'h00);
    send_frame("zero_byte", 0);
    chk("zero_byte_known_crc", m_crc, 32'hd202ef8d);
    take_result("zero_byte", 0);

    load_check_string();
    frm.push_back(8'h26); frm.push_back(8'h39); frm.push_back(8'hf4); frm.push_back(8'hcb);
    send_frame("residue", 0);
    chk("residue_known_ok", 32'(m_crc_ok), 32'd1);
    take_result("residue", 5);

    frm[3] = frm[3] ^ 8'h01;
    send_frame("residue_bad", 0);
    chk("residue_bad_known_ok", 32'(m_crc_ok), 32'd0);
    take_result("residue_bad", 2);

    load_check_string();
    send_frame("gaps_a", 40);
    chk("gaps_a_known_crc", m_crc, 32'hcbf43926);
    take_result("gaps_a", $urandom_range(3));
    send_frame("gaps_b", 40);
    chk("gaps_b_known_crc", m_crc, 32'hcbf43926);
    take_result("gaps_b", $urandom_range(3));

    for (int f = 0; f < 6; f++) begin
      frm.delete();
      for (int k = 0; k < $urandom_range(40, 1); k++) frm.push_back(8'($urandom));
      send_frame($sformatf("rand%0d", f), $urandom_range(50));
      take_result($sformatf("rand%0d", f), $urandom_range(4));
    end

    // Reset after 4 bytes of a frame.
    load_check_string();
    s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_data = frm[k];
      tick();
    end
    s_valid = 1'b0;
    chk("midframe_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midframe_rst_busy", 32'(busy), 32'd0);
    chk("midframe_rst_sready", 32'(s_ready), 32'd0);
    chk("midframe_rst_mvalid", 32'(m_valid), 32'd0);
    chk("midframe_rst_len", 32'(m_len), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    send_frame("after_rst", 0);
    chk("after_rst_known_crc", m_crc, 32'hcbf43926);
    take_result("after_rst", 0);

    // Reset while a result is pending.
    send_frame("pending", 0);
    chk("pending_valid", 32'(m_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midresult_rst_mvalid", 32'(m_valid), 32'd0);
    chk("midresult_rst_crc", m_crc, 32'd0);
    chk("midresult_rst_len", 32'(m_len), 32'd0);
    chk("midresult_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Longer than 65535 bytes: length saturates, CRC stays exact.
    frm.delete();
    for (int k = 0; k < 65537; k++) frm.push_back(8'($urandom));
    send_frame("long", 0);
    chk("long_len_sat", 32'(m_len), 32'hffff);
    take_result("long", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
